ifu: RTL and testbench
======================

# ifu

Instruction fetch unit for the single-cycle RV64 core. Owns the fetch PC, issues one instruction-memory read at a time over a valid/ready request channel, and presents the returned 32-bit instruction with its PC to the core through a valid/ready handshake. Accepts redirects (jal/jalr targets) from the core and discards any stale in-flight fetch.

## Interface

Parameters:
- RESET_PC, 64'h0000000080000000, first fetch address after reset
- NOP_INST, 32'h00000013, value driven on inst while no instruction is held

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- imem_req_valid  out  1  read request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  64  read address, word-aligned
- imem_resp_valid  in  1  read data valid; always accepted, never back-pressured
- imem_resp_data  in  32  instruction word
- inst_valid  out  1  inst/inst_pc valid to core
- inst_ready  in  1  core consumes inst this cycle
- inst  out  32  fetched instruction
- inst_pc  out  64  address of inst
- redirect_valid  in  1  core requests fetch restart
- redirect_pc  in  64  restart address; bits [1:0] ignored (forced 0)

## Operation

- States: IDLE, REQ, WAIT, HOLD. Register drop (1 bit) and pend_pc (64 bit).
- IDLE: entered only by reset; next cycle -> REQ.
- REQ: imem_req_valid=1, imem_req_addr=fetch pc. Address stable while valid && !ready. On handshake -> WAIT.
- WAIT: on imem_resp_valid: if drop, clear drop, pc<=pend_pc, -> REQ; else latch inst<=imem_resp_data, inst_pc<=pc, -> HOLD.
- HOLD: inst_valid=1. On inst_valid && inst_ready without redirect: pc<=pc+4 (64-bit, wraps modulo 2^64), -> REQ.
- Redirect handling (redirect_valid=1), target t = {redirect_pc[63:2],2'b00}:
  - HOLD: held inst discarded, pc<=t, -> REQ. Redirect wins over simultaneous inst_ready.
  - WAIT: drop<=1, pend_pc<=t; if imem_resp_valid same cycle, the response is discarded and pc<=t, -> REQ directly (drop stays 0).
  - REQ without handshake: pc<=t, request address changes (allowed only here, core redirect overrides stability rule; memory must treat it as a new request). REQ with handshake: -> WAIT with drop<=1, pend_pc<=t.
  - IDLE: pc<=t.
- Repeated redirects while drop=1 overwrite pend_pc; last one wins.
- imem_resp_valid outside WAIT is ignored.
- inst = NOP_INST whenever inst_valid=0.

## Timing

- Reset values: state=IDLE, pc=RESET_PC, imem_req_valid=0, imem_req_addr=RESET_PC, inst_valid=0, inst=NOP_INST, inst_pc=RESET_PC, drop=0, pend_pc=RESET_PC.
- Reset asserted mid-operation: all state returns to reset values immediately; outstanding response after release is ignored (state is IDLE/REQ, not WAIT).
- Zero-wait memory (req_ready=1, response one cycle after handshake): request cycle N, response N+1, inst_valid N+2. Peak throughput one instruction per 3 cycles with inst_ready=1.
- All outputs registered or decoded from state only; no combinational path from inst_ready or redirect_valid to any output.
- At most one outstanding request at any time.

## Structure

- Shared core package holds: ifu state enum (IDLE/REQ/WAIT/HOLD), RESET_PC and NOP_INST constants, XLEN=64.
- Single module; no sub-module is natural. PC+4 adder and state register inline.

## Test plan

- Reset release, req_ready=1, 1-cycle response 32'h00100093 -> imem_req_addr 0x80000000, inst_valid at cycle 3 after release with inst=32'h00100093, inst_pc=0x80000000; after inst_ready, next request 0x80000004.
- req_ready held 0 for 4 cycles -> imem_req_valid stays 1, address 0x80000000 stable, no state advance.
- Redirect to 0x80000103 while in WAIT -> returning data discarded, inst_valid stays 0, next request 0x80000100, its data delivered with inst_pc=0x80000100.
- Redirect to 0x80001000 in HOLD coincident with inst_ready=1 -> held inst dropped, next request 0x80001000, not 0x80000004.
- Two redirects (0x80002000 then 0x80003000) during one WAIT -> only 0x80003000 fetched next.
- Assert rst while in WAIT, then response arrives after release -> ignored; fetch restarts at 0x80000000, inst=NOP_INST while invalid.

Source files
------------

// File: rtl/ifu_pkg.sv
// Shared core definitions for the instruction fetch unit: widths, reset constants and FSM encoding.
package ifu_pkg;

    localparam int XLEN = 64;
    localparam int ILEN = 32;

    localparam logic [XLEN-1:0] IFU_RESET_PC = 64'h0000000080000000;
    localparam logic [ILEN-1:0] IFU_NOP_INST = 32'h00000013;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } ifu_state_e;

    // Clear bits [1:0] using every bit of the input so no bit is left unused.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return addr & ~{{(XLEN-2){1'b0}}, 2'b11};
    endfunction

endpackage

// File: rtl/ifu.sv
// Instruction fetch: one outstanding imem read, instruction handed to the core via valid/ready.
// Latency: request N, response N+1, inst_valid N+2 with zero-wait memory.
// Backpressure: request address held while imem_req_ready=0; instruction held until inst_ready or redirect.
module ifu
    import ifu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = IFU_RESET_PC,
    parameter logic [ILEN-1:0] NOP_INST = IFU_NOP_INST
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [ILEN-1:0] imem_resp_data,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [ILEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc
);

    ifu_state_e      state, state_nxt;
    logic [XLEN-1:0] pc, pc_nxt;
    logic [XLEN-1:0] pend_pc, pend_pc_nxt;
    logic            drop, drop_nxt;
    logic [ILEN-1:0] inst_q, inst_q_nxt;
    logic [XLEN-1:0] inst_pc_q, inst_pc_q_nxt;

    logic [XLEN-1:0] target;
    logic            req_fire;

    assign target   = word_align(redirect_pc);
    assign req_fire = (state == S_REQ) && imem_req_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            pc        <= RESET_PC;
            pend_pc   <= RESET_PC;
            drop      <= 1'b0;
            inst_q    <= NOP_INST;
            inst_pc_q <= RESET_PC;
        end else begin
            state     <= state_nxt;
            pc        <= pc_nxt;
            pend_pc   <= pend_pc_nxt;
            drop      <= drop_nxt;
            inst_q    <= inst_q_nxt;
            inst_pc_q <= inst_pc_q_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        pc_nxt        = pc;
        pend_pc_nxt   = pend_pc;
        drop_nxt      = drop;
        inst_q_nxt    = inst_q;
        inst_pc_q_nxt = inst_pc_q;

        case (state)
            S_IDLE: begin
                state_nxt = S_REQ;
                if (redirect_valid) begin
                    pc_nxt = target;
                end
            end

            S_REQ: begin
                if (req_fire) begin
                    state_nxt = S_WAIT;
                    // Request already accepted at the old pc; its data must be thrown away.
                    if (redirect_valid) begin
                        drop_nxt    = 1'b1;
                        pend_pc_nxt = target;
                    end
                end else if (redirect_valid) begin
                    pc_nxt = target;
                end
            end

            S_WAIT: begin
                if (redirect_valid) begin
                    if (imem_resp_valid) begin
                        pc_nxt    = target;
                        drop_nxt  = 1'b0;
                        state_nxt = S_REQ;
                    end else begin
                        drop_nxt    = 1'b1;
                        pend_pc_nxt = target;
                    end
                end else if (imem_resp_valid) begin
                    if (drop) begin
                        drop_nxt  = 1'b0;
                        pc_nxt    = pend_pc;
                        state_nxt = S_REQ;
                    end else begin
                        inst_q_nxt    = imem_resp_data;
                        inst_pc_q_nxt = pc;
                        state_nxt     = S_HOLD;
                    end
                end
            end

            S_HOLD: begin
                if (redirect_valid) begin
                    pc_nxt    = target;
                    state_nxt = S_REQ;
                end else if (inst_ready) begin
                    pc_nxt    = pc + 64'd4;
                    state_nxt = S_REQ;
                end
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign imem_req_valid = (state == S_REQ);
    assign imem_req_addr  = pc;
    assign inst_valid     = (state == S_HOLD);
    assign inst           = (state == S_HOLD) ? inst_q : NOP_INST;
    assign inst_pc        = inst_pc_q;

endmodule

// File: tb/tb_ifu.sv
module tb_ifu;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [63:0] inst_pc;
    logic        redirect_valid;
    logic [63:0] redirect_pc;

    int n_assert = 0;
    int n_fail   = 0;

    localparam logic [31:0] NOP = 32'h00000013;

    ifu dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst            (inst),
        .inst_pc         (inst_pc),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic rv, input logic [63:0] ra,
                           input logic iv, input logic [31:0] iw);
        chk({tag, ".req_valid"},  {63'd0, imem_req_valid}, {63'd0, rv});
        chk({tag, ".req_addr"},   imem_req_addr, ra);
        chk({tag, ".inst_valid"}, {63'd0, inst_valid}, {63'd0, iv});
        chk({tag, ".inst"},       {32'd0, inst}, {32'd0, iw});
    endtask

    initial begin
        rst             = 1'b1;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        inst_ready      = 1'b0;
        redirect_valid  = 1'b0;
        redirect_pc     = 64'h0;

        // Reset values
        tick();
        tick();
        chk_out("reset", 1'b0, 64'h80000000, 1'b0, NOP);
        chk("reset.inst_pc", inst_pc, 64'h80000000);
        rst = 1'b0;

        // Basic fetch with zero-wait memory
        tick();
        chk_out("t1.req", 1'b1, 64'h80000000, 1'b0, NOP);
        imem_req_ready = 1'b1;
        tick();
        chk_out("t1.wait", 1'b0, 64'h80000000, 1'b0, NOP);
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'h00100093;
        tick();
        chk_out("t1.hold", 1'b0, 64'h80000000, 1'b1, 32'h00100093);
        chk("t1.inst_pc", inst_pc, 64'h80000000);
        imem_resp_valid = 1'b0;
        inst_ready      = 1'b1;
        tick();
        chk_out("t1.next", 1'b1, 64'h80000004, 1'b0, NOP);
        inst_ready = 1'b0;

        // Memory stall; a stray response outside WAIT is ignored
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'hdeadbeef;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_out("t2.stall", 1'b1, 64'h80000004, 1'b0, NOP);
        end
        imem_resp_valid = 1'b0;

        // Redirect while waiting: returning data discarded
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h80000103;
        tick();
        chk_out("t3.drop_wait", 1'b0, 64'h80000004, 1'b0, NOP);
        redirect_valid  = 1'b0;
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'h11111111;
        tick();
        chk_out("t3.refetch", 1'b1, 64'h80000100, 1'b0, NOP);
        imem_resp_valid = 1'b0;
        imem_req_ready  = 1'b1;
        tick();
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'h22222222;
        tick();
        chk_out("t3.hold", 1'b0, 64'h80000100, 1'b1, 32'h22222222);
        chk("t3.inst_pc", inst_pc, 64'h80000100);
        imem_resp_valid = 1'b0;

        // Redirect in HOLD beats simultaneous inst_ready
        redirect_valid = 1'b1;
        redirect_pc    = 64'h80001000;
        inst_ready     = 1'b1;
        tick();
        chk_out("t4.redir_hold", 1'b1, 64'h80001000, 1'b0, NOP);
        redirect_valid = 1'b0;
        inst_ready     = 1'b0;

        // Two redirects during one WAIT: last wins
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h80002000;
        tick();
        redirect_pc    = 64'h80003000;
        tick();
        redirect_valid  = 1'b0;
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'h33333333;
        tick();
        chk_out("t5.last_wins", 1'b1, 64'h80003000, 1'b0, NOP);
        imem_resp_valid = 1'b0;

        // Redirect coincident with response in WAIT
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready  = 1'b0;
        redirect_valid  = 1'b1;
        redirect_pc     = 64'h80004000;
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'h44444444;
        tick();
        chk_out("t6.redir_resp", 1'b1, 64'h80004000, 1'b0, NOP);
        imem_resp_valid = 1'b0;

        // Redirect in REQ without handshake changes the address
        redirect_pc = 64'h8000500b;
        tick();
        chk_out("t7.req_redir", 1'b1, 64'h80005008, 1'b0, NOP);

        // Redirect in REQ with handshake: that response is dropped
        imem_req_ready = 1'b1;
        redirect_pc    = 64'h8000600c;
        tick();
        chk_out("t8.wait", 1'b0, 64'h80005008, 1'b0, NOP);
        redirect_valid  = 1'b0;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'h55555555;
        tick();
        chk_out("t8.refetch", 1'b1, 64'h8000600c, 1'b0, NOP);
        imem_resp_valid = 1'b0;

        // PC wraps modulo 2^64
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'h66666666;
        tick();
        chk("t9.inst_pc", inst_pc, 64'h8000600c);
        imem_resp_valid = 1'b0;
        redirect_valid  = 1'b1;
        redirect_pc     = 64'hffffffffffffffff;
        tick();
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'h77777777;
        tick();
        chk_out("t9.hold", 1'b0, 64'hfffffffffffffffc, 1'b1, 32'h77777777);
        chk("t9.inst_pc_top", inst_pc, 64'hfffffffffffffffc);
        imem_resp_valid = 1'b0;
        inst_ready      = 1'b1;
        tick();
        chk_out("t9.wrap", 1'b1, 64'h0, 1'b0, NOP);
        inst_ready = 1'b0;

        // Reset during WAIT; response after release ignored
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        chk_out("t10.wait", 1'b0, 64'h0, 1'b0, NOP);
        rst = 1'b1;
        #1;
        chk_out("t10.async_rst", 1'b0, 64'h80000000, 1'b0, NOP);
        tick();
        rst             = 1'b0;
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'h88888888;
        tick();
        chk_out("t10.restart", 1'b1, 64'h80000000, 1'b0, NOP);
        tick();
        chk_out("t10.ignored", 1'b1, 64'h80000000, 1'b0, NOP);
        imem_resp_valid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
